frame_double_buffer: RTL and testbench
======================================

# frame_double_buffer

Parametrised ping-pong frame store between the video decoder (writer) and the VGA scan-out (reader). Two banks of `2**ADDR_WIDTH` words live in one simple-dual-port block RAM addressed as {bank, addr}. The writer fills the back bank while the reader scans the front bank. Banks swap only at a reader frame boundary, so scan-out never shows a torn frame.

## Interface
- `DATA_WIDTH`, 8: pixel word width.
- `ADDR_WIDTH`, 17: per-bank address width. 320x240 = 76800 words fits.
- `RPT_WIDTH`, 16: width of the repeated-frame counter.

- `clk`  in  1  : single clock for all logic.
- `rst_n`  in  1  : synchronous reset, active-low.
- `wr_en`  in  1  : write strobe. Accepted only when `wr_ready`=1.
- `wr_addr`  in  ADDR_WIDTH  : back-bank write address.
- `wr_data`  in  DATA_WIDTH  : write data.
- `wr_frame_done`  in  1  : pulse; the back bank holds a complete frame.
- `wr_ready`  out  1  : the back bank accepts writes.
- `rd_frame_start`  in  1  : pulse at reader vsync; the only point where a swap occurs.
- `rd_en`  in  1  : read strobe.
- `rd_addr`  in  ADDR_WIDTH  : front-bank read address.
- `rd_data`  out  DATA_WIDTH  : read data.
- `rd_valid`  out  1  : `rd_data` is valid this cycle.
- `front_bank`  out  1  : index of the bank being displayed.
- `rpt_count`  out  RPT_WIDTH  : number of frames re-displayed because no new frame was ready. Saturates.
- `overrun`  out  1  : sticky; `wr_frame_done` arrived while PENDING.

## Operation
- **FSM**
  - FILL: `wr_ready`=1.
  - PENDING: `wr_ready`=0.
  - Transitions:
    - FILL, `wr_frame_done` and no `rd_frame_start` -> PENDING.
    - PENDING, `rd_frame_start` -> toggle `front_bank`, go to FILL.
    - FILL, `wr_frame_done` and `rd_frame_start` in the same cycle -> toggle `front_bank`, stay in FILL.
    - FILL, `rd_frame_start` alone -> no swap; `rpt_count` += 1, saturating at all-ones.
    - PENDING, `wr_frame_done` -> ignored; set `overrun`.
- **Write path**
  - The write is committed when `wr_en && wr_ready`.
  - Physical address = {~front_bank, wr_addr}, using `front_bank` as it is before the clock edge.
  - A write in the same cycle as a swap lands in the bank that becomes front.
  - `wr_en` while `wr_ready`=0 is dropped silently; RAM is unchanged.
- **Read path**
  - Physical address = {front_bank, rd_addr}, using pre-edge `front_bank`.
  - A read issued in the swap cycle returns old-front data.
  - Reads and writes never target the same bank, so no collision logic is needed.
- **Reset (`rst_n`=0 at a clk edge)**
  - State → FILL; `front_bank`=0; `wr_ready`=1 (combinational from state); `rd_valid`=0; `rpt_count`=0; `overrun`=0.
  - `rd_data` is don't-care until the first `rd_valid`.
  - RAM contents are not cleared.
  - Reset mid-frame discards the pending state; the in-flight read produces no `rd_valid`.

## Timing
- Read latency L = 1 (2 with `FRAME_BUF_OUTREG_EN`): `rd_en` at cycle N gives `rd_valid`=1 with data at cycle N+L. Fully pipelined, one read per cycle.
- Write-to-read visibility: a word written at cycle N is readable once its bank is front, i.e. after a swap at cycle ≥ N.
- Swap: `front_bank` changes at the edge where `rd_frame_start` is sampled. `wr_ready` rises on that same edge.
- PENDING is entered at the edge sampling `wr_frame_done`; `wr_ready` is 0 from the next cycle.

## Configuration
- `FRAME_BUF_OUTREG_EN`
  - Defined: adds a second register stage on `rd_data`/`rd_valid`; L = 2. That register's data is reset to 0.
  - Undefined: `rd_data` is the RAM output register directly; L = 1.
- FSM and write behaviour are identical in both builds.

## Structure
- Package `frame_buf_pkg` holds:
  - the state encoding (FILL=0, PENDING=1);
  - the `BANK_SEL_W`=1 constant;
  - a helper for physical address width (`ADDR_WIDTH`+1).
- Sub-module `simple_dual_port_ram`:
  - one write port, one read port, single clock;
  - no reset;
  - registered read, coded so it infers block RAM;
  - depth `2**(ADDR_WIDTH+1)`.
- The top level contains the FSM, bank select, counters and the optional output stage.

## Test plan
- **Reset defaults:** after reset, check `wr_ready`=1, `front_bank`=0, `rpt_count`=0, `overrun`=0, `rd_valid`=0.
- **Basic swap:** write 0xA5 to addr 5, pulse `wr_frame_done`, then `rd_frame_start` -> `front_bank`=1. `rd_en` on addr 5 returns 0xA5 with `rd_valid` exactly L cycles later.
- **Writes blocked while PENDING:**
  - In PENDING, `wr_en` with 0x3C to addr 5 -> RAM unchanged.
  - After the swap and a second fill with 0x11, addr 5 of the old bank still reads 0xA5.
- **Repeat counting:**
  - Three `rd_frame_start` pulses with no `wr_frame_done` -> `rpt_count`=3 and `front_bank` unchanged.
  - With `RPT_WIDTH`=2, five pulses -> `rpt_count`=3 (saturated).
- **Simultaneous events:**
  - `wr_frame_done` and `rd_frame_start` in the same cycle -> swap, state stays FILL, `wr_ready` stays 1.
  - A second `wr_frame_done` while PENDING -> `overrun`=1, which stays 1 until reset.
- **Mid-operation reset:** `rst_n`=0 during a read burst and while PENDING -> the next cycle shows `rd_valid`=0, `wr_ready`=1, `front_bank`=0.

Source files
------------

// File: rtl/frame_double_buffer_pkg.sv
// frame_buf_pkg: state encoding and physical-address helpers shared by frame_double_buffer
package frame_buf_pkg;

    typedef enum logic {
        FILL    = 1'b0,
        PENDING = 1'b1
    } state_t;

    localparam int BANK_SEL_W = 1;

    function automatic int phys_addr_w(input int addr_width);
        return addr_width + BANK_SEL_W;
    endfunction

endpackage

// File: rtl/frame_double_buffer_if.sv
// frame_double_buffer_if: writer, reader and status signals of the ping-pong frame store
interface frame_double_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 17,
    parameter int RPT_WIDTH  = 16
);
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_frame_done;
    logic                  wr_ready;
    logic                  rd_frame_start;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  front_bank;
    logic [RPT_WIDTH-1:0]  rpt_count;
    logic                  overrun;

    modport master (
        output wr_en, wr_addr, wr_data, wr_frame_done, rd_frame_start, rd_en, rd_addr,
        input  wr_ready, rd_data, rd_valid, front_bank, rpt_count, overrun
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_frame_done, rd_frame_start, rd_en, rd_addr,
        output wr_ready, rd_data, rd_valid, front_bank, rpt_count, overrun
    );
endinterface

// File: rtl/frame_double_buffer_ram.sv
// simple_dual_port_ram: one write port, one registered read port, both banks in one array
module simple_dual_port_ram
    import frame_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                                  clk,
    input  logic                                  we,
    input  logic [phys_addr_w(ADDR_WIDTH)-1:0]    waddr,
    input  logic [DATA_WIDTH-1:0]                 wdata,
    input  logic                                  re,
    input  logic [phys_addr_w(ADDR_WIDTH)-1:0]    raddr,
    output logic [DATA_WIDTH-1:0]                 rdata
);
    localparam int PAW = phys_addr_w(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [2**PAW];

    // Unreset write and registered read so the array maps onto block RAM
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/frame_double_buffer.sv
// frame_double_buffer: ping-pong frame store; FRAME_BUF_OUTREG_EN adds a read output register
module frame_double_buffer
    import frame_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 17,
    parameter int RPT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    frame_double_buffer_if.slave bus
);
    localparam int PAW = phys_addr_w(ADDR_WIDTH);

    state_t                state_q, state_d;
    logic                  front_q;
    logic                  swap;
    logic                  rpt_inc;
    logic                  ovr_set;
    logic                  wr_ready;
    logic                  rd_valid_q;
    logic                  overrun_q;
    logic [RPT_WIDTH-1:0]  rpt_q;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [PAW-1:0]        waddr;
    logic [PAW-1:0]        raddr;

    assign wr_ready = (state_q == FILL);
    // Writer owns the back bank, reader the front; front_q is pre-edge so swap-cycle accesses hit the old banks
    assign waddr    = {~front_q, bus.wr_addr};
    assign raddr    = {front_q, bus.rd_addr};

    // Next state, swap and counter strobes; swaps only ever happen on a reader frame start
    always_comb begin
        state_d = state_q;
        swap    = 1'b0;
        rpt_inc = 1'b0;
        ovr_set = 1'b0;
        if (state_q == FILL) begin
            swap    = bus.wr_frame_done && bus.rd_frame_start;
            rpt_inc = bus.rd_frame_start && !bus.wr_frame_done;
            state_d = (bus.wr_frame_done && !bus.rd_frame_start) ? PENDING : FILL;
        end else begin
            swap    = bus.rd_frame_start;
            ovr_set = bus.wr_frame_done;
            state_d = bus.rd_frame_start ? FILL : PENDING;
        end
    end

    // State, bank select, saturating repeat counter, sticky overrun and read-valid pipeline
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FILL;
            front_q    <= 1'b0;
            rpt_q      <= '0;
            overrun_q  <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            front_q    <= front_q ^ swap;
            overrun_q  <= overrun_q | ovr_set;
            rd_valid_q <= bus.rd_en;
            if (rpt_inc && !(&rpt_q)) rpt_q <= rpt_q + RPT_WIDTH'(1);
        end
    end

    simple_dual_port_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (bus.wr_en && wr_ready),
        .waddr(waddr),
        .wdata(bus.wr_data),
        .re   (bus.rd_en),
        .raddr(raddr),
        .rdata(ram_q)
    );

`ifdef FRAME_BUF_OUTREG_EN
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q2;

    // Extra output stage for timing; it is reset so nothing stale leaks after reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q   <= '0;
            rd_valid_q2 <= 1'b0;
        end else begin
            rd_data_q   <= ram_q;
            rd_valid_q2 <= rd_valid_q;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q2;
`else
    assign bus.rd_data  = ram_q;
    assign bus.rd_valid = rd_valid_q;
`endif

    assign bus.wr_ready   = wr_ready;
    assign bus.front_bank = front_q;
    assign bus.rpt_count  = rpt_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_frame_double_buffer.sv
// tb_frame_double_buffer: directed stimulus with a read scoreboard for frame_double_buffer
module tb_frame_double_buffer;
`ifdef FRAME_BUF_OUTREG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   m_checks = 0;
    int   m_fails = 0;
    exp_t q[$];
    exp_t e;

    frame_double_buffer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .RPT_WIDTH(2)) bus ();

    frame_double_buffer #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .RPT_WIDTH(2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1) begin
            m_checks = m_checks + 1;
            if (q.size() == 0) begin
                m_fails = m_fails + 1;
                $display("FAIL rd_unexpected: rd_valid=1 data=0x%0h at cycle %0d, required no read outstanding", bus.rd_data, cyc);
            end else begin
                e = q.pop_front();
                if (bus.rd_data !== e.d || cyc != e.c) begin
                    m_fails = m_fails + 1;
                    $display("FAIL rd_data: got 0x%0h at cycle %0d, required 0x%0h at cycle %0d", bus.rd_data, cyc, e.d, e.c);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus.wr_en = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] d);
        bus.rd_en = 1'b1;
        bus.rd_addr = a;
        q.push_back('{d, cyc + L});
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic events(input logic done, input logic start);
        bus.wr_frame_done = done;
        bus.rd_frame_start = start;
        tick();
        bus.wr_frame_done = 1'b0;
        bus.rd_frame_start = 1'b0;
    endtask

    initial begin
        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.wr_frame_done = 1'b0;
        bus.rd_frame_start = 1'b0;
        bus.rd_en = 1'b0;
        bus.rd_addr = '0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("reset_wr_ready", 32'(bus.wr_ready), 1);
        chk("reset_front_bank", 32'(bus.front_bank), 0);
        chk("reset_rpt_count", 32'(bus.rpt_count), 0);
        chk("reset_overrun", 32'(bus.overrun), 0);
        chk("reset_rd_valid", 32'(bus.rd_valid), 0);

        wr(8'd5, 8'hA5);
        wr(8'd6, 8'h77);
        events(1'b1, 1'b0);
        chk("pending_wr_ready", 32'(bus.wr_ready), 0);
        wr(8'd5, 8'h3C);
        chk("pending_front_bank", 32'(bus.front_bank), 0);
        events(1'b0, 1'b1);
        chk("swap_front_bank", 32'(bus.front_bank), 1);
        chk("swap_wr_ready", 32'(bus.wr_ready), 1);
        rd(8'd5, 8'hA5);
        rd(8'd6, 8'h77);

        bus.wr_en = 1'b1;
        bus.wr_addr = 8'd5;
        bus.wr_data = 8'h11;
        events(1'b1, 1'b1);
        bus.wr_en = 1'b0;
        chk("simul_front_bank", 32'(bus.front_bank), 0);
        chk("simul_wr_ready", 32'(bus.wr_ready), 1);
        chk("simul_rpt_count", 32'(bus.rpt_count), 0);
        rd(8'd5, 8'h11);

        events(1'b1, 1'b0);
        bus.rd_en = 1'b1;
        bus.rd_addr = 8'd5;
        q.push_back('{8'h11, cyc + L});
        events(1'b0, 1'b1);
        bus.rd_en = 1'b0;
        chk("swapback_front_bank", 32'(bus.front_bank), 1);
        rd(8'd5, 8'hA5);

        for (int i = 0; i < 3; i++) events(1'b0, 1'b1);
        chk("rpt_three", 32'(bus.rpt_count), 3);
        chk("rpt_front_bank", 32'(bus.front_bank), 1);
        for (int i = 0; i < 2; i++) events(1'b0, 1'b1);
        chk("rpt_saturate", 32'(bus.rpt_count), 3);

        events(1'b1, 1'b0);
        chk("ovr_before", 32'(bus.overrun), 0);
        events(1'b1, 1'b0);
        chk("ovr_set", 32'(bus.overrun), 1);
        chk("ovr_wr_ready", 32'(bus.wr_ready), 0);
        events(1'b0, 1'b1);
        chk("ovr_sticky", 32'(bus.overrun), 1);
        chk("ovr_front_bank", 32'(bus.front_bank), 0);

        events(1'b1, 1'b0);
        chk("midrst_pending", 32'(bus.wr_ready), 0);
        rd(8'd5, 8'h11);
        bus.rd_en = 1'b1;
        rst_n = 1'b0;
        while (q.size() > 0 && q[$].c >= cyc + 1) void'(q.pop_back());
        tick();
        bus.rd_en = 1'b0;
        rst_n = 1'b1;
        chk("midrst_rd_valid", 32'(bus.rd_valid), 0);
        chk("midrst_wr_ready", 32'(bus.wr_ready), 1);
        chk("midrst_front_bank", 32'(bus.front_bank), 0);
        chk("midrst_overrun", 32'(bus.overrun), 0);
        chk("midrst_rpt_count", 32'(bus.rpt_count), 0);

        for (int i = 0; i < 4; i++) tick();
        chk("rd_drain", 32'(q.size()), 0);
        $display("%0d/%0d checks passed", (checks + m_checks) - (fails + m_fails), checks + m_checks);
        $finish;
    end
endmodule
